alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 163 ++++++++++++++++
 tb/tb_alu_issue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: single-issue command front end for an external combinational ALU.
//
// Each command passes through IDLE -> EXEC -> DONE, so at most one command
// is accepted every three cycles.
//   IDLE : cmd_ready = 1. Accepting a command captures its fields and reads
//          the rs and rt operands from the register file.
//   EXEC : alu_a, alu_b and alu_op are driven from registers. On the closing
//          edge the result (cmd_imm for li, alu_y otherwise) is written to rd
//          and captured into res_data/res_rd. ALU commands also load the flags.
//   DONE : res_valid is high for this one cycle.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake. Strict valid/ready: a command
//                        transfers on a rising edge where both are high.
//                        cmd_valid may be held, and cmd_* are ignored while
//                        cmd_ready is low.
//   cmd_op/li/rd/rs/rt/imm  command fields
//   alu_a/alu_b/alu_op   operands and opcode sent to the downstream ALU
//   alu_y/cout/zero      ALU result and flags
//   res_valid/data/rd    write-back report; res_valid pulses for one cycle
//   flag_c/flag_z        sticky flags from the most recent ALU command
//   dbg_addr/dbg_data    combinational register-file read port
//   dbg_state            current FSM state (0 IDLE, 1 EXEC, 2 DONE)
module alu_issue #(
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_li,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs,
  input  logic [REG_AW-1:0] cmd_rt,
  input  logic [31:0]       cmd_imm,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_op,
  input  logic [31:0]       alu_y,
  input  logic              alu_cout,
  input  logic              alu_zero,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic [REG_AW-1:0] res_rd,
  output logic              flag_c,
  output logic              flag_z,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_data,
  output logic [1:0]        dbg_state
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       rf [NREG];
  logic [2:0]        op_q;
  logic              li_q;
  logic [REG_AW-1:0] rd_q;
  logic [31:0]       imm_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;

  logic              accept;
  logic              exec_end;
  logic [31:0]       result;
  logic [31:0]       rs_val;
  logic [31:0]       rt_val;

  // Register 0 is forced to zero on every read port. It is never written
  // anyway, but the explicit mux keeps that true by construction.
  assign rs_val   = (cmd_rs   == '0) ? 32'd0 : rf[cmd_rs];
  assign rt_val   = (cmd_rt   == '0) ? 32'd0 : rf[cmd_rt];
  assign dbg_data = (dbg_addr == '0) ? 32'd0 : rf[dbg_addr];

  assign accept   = cmd_valid && (state_q == IDLE);
  assign exec_end = (state_q == EXEC);
  assign result   = li_q ? imm_q : alu_y;

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = EXEC;
      end
      EXEC: state_d = DONE;
      DONE: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture, operand read and write-back reporting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= 3'd0;
      li_q     <= 1'b0;
      rd_q     <= '0;
      imm_q    <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      res_data <= 32'd0;
      res_rd   <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        li_q  <= cmd_li;
        rd_q  <= cmd_rd;
        imm_q <= cmd_imm;
        a_q   <= rs_val;
        b_q   <= rt_val;
      end
      if (exec_end) begin
        // A write to r0 is discarded, but the computed value is still reported.
        res_data <= result;
        res_rd   <= rd_q;
        if (!li_q) begin
          flag_c <= alu_cout;
          flag_z <= alu_zero;
        end
      end
    end
  end

  // Register file. Writes land on the edge that closes EXEC, so they are
  // visible to the next accept (at least two edges later) without a bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= 32'd0;
    end else if (exec_end && (rd_q != '0)) begin
      rf[rd_q] <= result;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue. A small combinational ALU stands in for the
// downstream unit, and a shadow register file supplies the expected operands.
module tb_alu_issue;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_li;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rs;
  logic [2:0]  cmd_rt;
  logic [31:0] cmd_imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_y;
  logic        alu_cout;
  logic        alu_zero;
  logic        res_valid;
  logic [31:0] res_data;
  logic [2:0]  res_rd;
  logic        flag_c;
  logic        flag_z;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  int          n_checks;
  int          n_pass;
  logic [31:0] model [8];
  logic [31:0] exp_q [$];

  alu_issue #(.REG_AW(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_li    (cmd_li),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .alu_cout  (alu_cout),
    .alu_zero  (alu_zero),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // Clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ALU: SUB carry is the carry-out of a + ~b + 1, SHL1 reports
  // no carry, and reserved opcodes return zero.
  logic [32:0] alu_t;
  always_comb begin
    alu_t = 33'd0;
    case (alu_op)
      3'b000:  alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      3'b010:  alu_t = {1'b0, alu_a & alu_b};
      3'b011:  alu_t = {1'b0, alu_a | alu_b};
      3'b100:  alu_t = {1'b0, alu_a << 1};
      default: alu_t = 33'd0;
    endcase
  end
  assign alu_y    = alu_t[31:0];
  assign alu_cout = alu_t[32];
  assign alu_zero = (alu_t[31:0] == 32'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one command from IDLE through DONE and check every stage. The task
  // returns in the low phase of DONE.
  task automatic do_cmd(input string tag, input logic li, input logic [2:0] op,
                        input int rd, input int rs, input int rt,
                        input logic [31:0] imm, input logic [31:0] exp_y,
                        input logic exp_c, input logic exp_z);
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_li    = li;
    cmd_op    = op;
    cmd_rd    = 3'(rd);
    cmd_rs    = 3'(rs);
    cmd_rt    = 3'(rt);
    cmd_imm   = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_ready_exec"}, 32'(cmd_ready), 32'd0);
    check({tag, "_valid_exec"}, 32'(res_valid), 32'd0);
    check({tag, "_alu_a"}, alu_a, model[rs]);
    check({tag, "_alu_b"}, alu_b, model[rt]);
    check({tag, "_alu_op"}, 32'(alu_op), 32'(op));
    @(negedge clk);
    check({tag, "_valid_done"}, 32'(res_valid), 32'd1);
    check({tag, "_data"}, res_data, exp_y);
    check({tag, "_rd"}, 32'(res_rd), 32'(rd));
    check({tag, "_flag_c"}, 32'(flag_c), 32'(exp_c));
    check({tag, "_flag_z"}, 32'(flag_z), 32'(exp_z));
    if (rd != 0) model[rd] = exp_y;
    dbg_addr = 3'(rd);
    #1;
    check({tag, "_dbg"}, dbg_data, model[rd]);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_li    = 1'b0;
    cmd_rd    = 3'd0;
    cmd_rs    = 3'd0;
    cmd_rt    = 3'd0;
    cmd_imm   = 32'd0;
    dbg_addr  = 3'd0;
    for (int i = 0; i < 8; i++) model[i] = 32'd0;

    // Outputs held at their reset values
    repeat (2) @(negedge clk);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_rd", 32'(res_rd), 32'd0);
    check("rst_flags", {30'd0, flag_c, flag_z}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_ready_after", 32'(cmd_ready), 32'd1);

    // Directed vectors: tag li op rd rs rt imm expected-data c z
    do_cmd("li_r1",  1'b1, 3'b000, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_cmd("li_r2",  1'b1, 3'b000, 2, 0, 0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    do_cmd("add_r3", 1'b0, 3'b000, 3, 1, 2, 32'd0,         32'h0000_0000, 1'b1, 1'b1);
    do_cmd("sub_r4", 1'b0, 3'b001, 4, 2, 1, 32'd0,         32'h0000_0002, 1'b0, 1'b0);
    do_cmd("shl_r5", 1'b0, 3'b100, 5, 1, 2, 32'd0,         32'hFFFF_FFFE, 1'b0, 1'b0);
    do_cmd("and_r6", 1'b0, 3'b010, 6, 5, 4, 32'd0,         32'h0000_0002, 1'b0, 1'b0);
    do_cmd("or_r7",  1'b0, 3'b011, 7, 4, 2, 32'd0,         32'h0000_0003, 1'b0, 1'b0);
    do_cmd("rsv111", 1'b0, 3'b111, 6, 1, 2, 32'd0,         32'h0000_0000, 1'b0, 1'b1);
    // LI to r0 reports its value, writes nothing and keeps c=0 z=1
    do_cmd("li_r0",  1'b1, 3'b001, 0, 0, 0, 32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1);
    dbg_addr = 3'd4;
    #1;
    check("dbg_r4", dbg_data, 32'h0000_0002);

    // cmd_valid held for 9 cycles with a different LI every cycle: ready
    // goes 1,0,0 and only cycles 0, 3 and 6 are accepted.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (res_valid) begin
        if (exp_q.size() == 0) check("held_unexpected_valid", 32'(res_valid), 32'd0);
        else check("held_data", res_data, exp_q.pop_front());
      end
      check("held_ready", 32'(cmd_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
      cmd_valid = 1'b1;
      cmd_li    = 1'b1;
      cmd_op    = 3'(i);
      cmd_rd    = 3'((i % 7) + 1);
      cmd_imm   = 32'h100 + 32'(i);
      if (i % 3 == 0) begin
        exp_q.push_back(32'h100 + 32'(i));
        model[(i % 7) + 1] = 32'h100 + 32'(i);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_all_results", 32'(exp_q.size()), 32'd0);
    dbg_addr = 3'd7;
    #1;
    check("held_dbg_r7", dbg_data, 32'h0000_0106);

    // Reset in the middle of EXEC of ADD r6 = r1 + r2
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_li    = 1'b0;
    cmd_op    = 3'b000;
    cmd_rd    = 3'd6;
    cmd_rs    = 3'd1;
    cmd_rt    = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_alu_a", alu_a, model[1]);
    reset = 1'b1;
    #1;
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_flag_z", 32'(flag_z), 32'd0);
    check("mid_rst_res_data", res_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", 32'(res_valid), 32'd0);
    end
    for (int i = 0; i < 8; i++) model[i] = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Accepted on the first edge after deassertion
    do_cmd("post_rst_li_r7", 1'b1, 3'b000, 7, 1, 2, 32'hCAFE_0001, 32'hCAFE_0001, 1'b0, 1'b0);
    for (int a = 1; a < 7; a++) begin
      dbg_addr = 3'(a);
      #1;
      check("post_rst_dbg_clear", dbg_data, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
